// File: rtl/dataram_ctrl.sv
// Two-port round-robin sequencer in front of DATARAM. Bit operations are
// turned into byte-mode read-modify-write cycles on the bit-addressable area.
module dataram_ctrl #(
  parameter logic [7:0] BIT_BASE  = 8'h20,
  parameter logic [7:0] BIT_LIMIT = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c_req,
  input  logic [2:0] c_op,
  input  logic [7:0] c_addr,
  input  logic [7:0] c_wdata,
  input  logic       c_wbit,
  output logic       c_ack,
  output logic [7:0] c_rdata,
  output logic       c_rbit,
  output logic       c_err,
  input  logic       a_req,
  input  logic [2:0] a_op,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  input  logic       a_wbit,
  output logic       a_ack,
  output logic [7:0] a_rdata,
  output logic       a_rbit,
  output logic       a_err,
  output logic       ram_CS,
  output logic       ram_RW,
  output logic       ram_Bb,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_RDB   = 3'd0,
    OP_WRB   = 3'd1,
    OP_RDBIT = 3'd2,
    OP_SETB  = 3'd3,
    OP_CLRB  = 3'd4,
    OP_CPLB  = 3'd5,
    OP_MOVB  = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  state_t     state, nxt;
  logic       gnt_a, prio_a;
  op_t        lop;
  logic       lbit, lwbit;
  logic [7:0] taddr, wbyte, old;
  logic [2:0] bidx;

  logic       any_req, pick_a, done_a, done_go;
  op_t        sop;
  logic [7:0] saddr, swdata;
  logic       swbit, s_isbit, s_rej;
  logic       nbit;
  logic [7:0] newbyte;
  logic [7:0] res_rdata;
  logic       res_rbit, res_err;

  // Request selection: on a tie the port not granted last wins.
  always_comb begin
    any_req = c_req | a_req;
    pick_a  = a_req & (~c_req | prio_a);
    sop     = op_t'(pick_a ? a_op : c_op);
    saddr   = pick_a ? a_addr  : c_addr;
    swdata  = pick_a ? a_wdata : c_wdata;
    swbit   = pick_a ? a_wbit  : c_wbit;
    s_isbit = sop inside {OP_RDBIT, OP_SETB, OP_CLRB, OP_CPLB, OP_MOVB};
    s_rej   = (sop == OP_RSVD) || (s_isbit && (saddr >= BIT_LIMIT));
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          if (s_rej)                nxt = S_DONE;
          else if (sop == OP_WRB)   nxt = S_WR;
          else                      nxt = S_RD;
        end
      end
      S_RD:    nxt = S_CAP;
      S_CAP:   nxt = (lop == OP_RDB || lop == OP_RDBIT) ? S_DONE : S_WR;
      S_WR:    nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (lop)
      OP_SETB: nbit = 1'b1;
      OP_CLRB: nbit = 1'b0;
      OP_CPLB: nbit = ~ram_dout[bidx];
      default: nbit = lwbit;
    endcase
    newbyte       = ram_dout;
    newbyte[bidx] = nbit;
  end

  // Results are taken on the edge entering DONE; the source depends on the
  // state we leave (rejection from IDLE, read from CAP, RMW/WRB from WR).
  always_comb begin
    res_rdata = '0;
    res_rbit  = 1'b0;
    res_err   = 1'b0;
    case (state)
      S_IDLE: res_err = 1'b1;
      S_CAP: begin
        res_rdata = ram_dout;
        res_rbit  = lbit & ram_dout[bidx];
      end
      S_WR: begin
        res_rdata = old;
        res_rbit  = lbit & old[bidx];
      end
      default: ;
    endcase
    done_go = (nxt == S_DONE) && (state != S_DONE);
    done_a  = (state == S_IDLE) ? pick_a : gnt_a;
  end

  always_comb begin
    ram_CS   = ~((state == S_RD) || (state == S_WR));
    ram_RW   = (state != S_WR);
    ram_Bb   = 1'b1;
    ram_addr = ((state == S_RD) || (state == S_WR)) ? taddr : '0;
    ram_din  = (state == S_WR) ? wbyte : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      gnt_a  <= 1'b0;
      prio_a <= 1'b0;
      lop    <= OP_RDB;
      lbit   <= 1'b0;
      lwbit  <= 1'b0;
      taddr  <= '0;
      bidx   <= '0;
      wbyte  <= '0;
      old    <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && any_req) begin
        gnt_a  <= pick_a;
        prio_a <= ~pick_a;
        lop    <= sop;
        lbit   <= s_isbit;
        lwbit  <= swbit;
        taddr  <= s_isbit ? BIT_BASE + {4'b0000, saddr[6:3]} : saddr;
        bidx   <= saddr[2:0];
        wbyte  <= swdata;
        old    <= '0;
      end
      if (state == S_CAP) begin
        old   <= ram_dout;
        wbyte <= newbyte;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_ack   <= 1'b0;
      c_rdata <= '0;
      c_rbit  <= 1'b0;
      c_err   <= 1'b0;
      a_ack   <= 1'b0;
      a_rdata <= '0;
      a_rbit  <= 1'b0;
      a_err   <= 1'b0;
    end else begin
      c_ack <= done_go & ~done_a;
      a_ack <= done_go & done_a;
      if (done_go && !done_a) begin
        c_rdata <= res_rdata;
        c_rbit  <= res_rbit;
        c_err   <= res_err;
      end
      if (done_go && done_a) begin
        a_rdata <= res_rdata;
        a_rbit  <= res_rbit;
        a_err   <= res_err;
      end
    end
  end

endmodule

// File: tb/tb_dataram_ctrl.sv
// Bench for dataram_ctrl: behavioural RAM, byte-array reference model applied
// in completion order, directed cases followed by randomized two-port traffic.
module tb_dataram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       c_req, c_wbit, c_ack, c_rbit, c_err;
  logic [2:0] c_op;
  logic [7:0] c_addr, c_wdata, c_rdata;
  logic       a_req, a_wbit, a_ack, a_rbit, a_err;
  logic [2:0] a_op;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic       ram_CS, ram_RW, ram_Bb;
  logic [7:0] ram_addr, ram_din, ram_dout;

  dataram_ctrl #(.BIT_BASE(8'h20), .BIT_LIMIT(8'h80)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata), .c_wbit(c_wbit),
    .c_ack(c_ack), .c_rdata(c_rdata), .c_rbit(c_rbit), .c_err(c_err),
    .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata), .a_wbit(a_wbit),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_rbit(a_rbit), .a_err(a_err),
    .ram_CS(ram_CS), .ram_RW(ram_RW), .ram_Bb(ram_Bb),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural DATARAM: read data appears the cycle after the read cycle.
  logic [7:0]  mem     [256] = '{default: 8'h00};
  logic [7:0]  ref_mem [256] = '{default: 8'h00};
  int unsigned wr_cnt = 0;
  int unsigned cs_cnt = 0;
  initial ram_dout = 8'h00;
  always @(posedge clk) begin
    if (ram_CS === 1'b0) begin
      cs_cnt <= cs_cnt + 1;
      if (ram_RW === 1'b0) begin
        mem[ram_addr] <= ram_din;
        wr_cnt <= wr_cnt + 1;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int last_ack = -1;
  bit chk_alt = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit isbit(input logic [2:0] op);
    return (op >= 3'd2) && (op <= 3'd6);
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [7:0] addr);
    if (op == 3'd7 || (isbit(op) && addr >= 8'h80)) return 1;
    if (op == 3'd1) return 2;
    if (op == 3'd0 || op == 3'd2) return 3;
    return 4;
  endfunction

  function automatic void ref_exec(input logic [2:0] op, input logic [7:0] addr,
                                   input logic [7:0] wd, input logic wb,
                                   output logic [7:0] rd, output logic rb, output logic er);
    logic [7:0] b, o;
    int idx;
    rd = '0; rb = 1'b0; er = 1'b0;
    if (op == 3'd7 || (isbit(op) && addr >= 8'h80)) begin
      er = 1'b1;
    end else if (op == 3'd0) begin
      rd = ref_mem[addr];
    end else if (op == 3'd1) begin
      ref_mem[addr] = wd;
    end else begin
      b   = 8'h20 + addr / 8;
      idx = addr % 8;
      o   = ref_mem[b];
      rd  = o;
      rb  = o[idx];
      case (op)
        3'd3: o[idx] = 1'b1;
        3'd4: o[idx] = 1'b0;
        3'd5: o[idx] = ~o[idx];
        3'd6: o[idx] = wb;
        default: ;
      endcase
      ref_mem[b] = o;
    end
  endfunction

  // Issue one request on port p (0=C, 1=A) and check its completion.
  task automatic do_txn(input int p, input logic [2:0] op, input logic [7:0] addr,
                        input logic [7:0] wd, input logic wb, input bit lat);
    int n = 0;
    logic ack = 1'b0;
    logic oth, rb, er, erb, eer;
    logic [7:0] rd, erd;
    if (p == 0) begin c_op = op; c_addr = addr; c_wdata = wd; c_wbit = wb; c_req = 1'b1; end
    else        begin a_op = op; a_addr = addr; a_wdata = wd; a_wbit = wb; a_req = 1'b1; end
    while (!ack && n < 40) begin
      @(posedge clk); #1;
      n++;
      ack = (p == 0) ? c_ack : a_ack;
    end
    chk("ack_seen", ack, 1);
    if (p == 0) begin c_req = 1'b0; rd = c_rdata; rb = c_rbit; er = c_err; oth = a_ack; end
    else        begin a_req = 1'b0; rd = a_rdata; rb = a_rbit; er = a_err; oth = c_ack; end
    if (!ack) return;
    ref_exec(op, addr, wd, wb, erd, erb, eer);
    chk("err", er, eer);
    chk("rdata", rd, erd);
    if (isbit(op) || eer) chk("rbit", rb, erb);
    chk("ack_excl", oth, 0);
    chk("cs_at_ack", ram_CS, 1);
    chk("bytemode", ram_Bb, 1);
    if (lat) chk("latency", n, exp_lat(op, addr));
    if (chk_alt && last_ack >= 0) chk("rr_alt", p, 1 - last_ack);
    last_ack = p;
    if (lat) begin @(posedge clk); #1; end
  endtask

  task automatic rand_port(input int p, input int cnt);
    logic [2:0] op;
    logic [7:0] ad;
    for (int k = 0; k < cnt; k++) begin
      op = 3'($urandom_range(0, 7));
      ad = isbit(op) ? 8'($urandom_range(0, 8'h9F)) : 8'(8'h20 + $urandom_range(0, 15));
      do_txn(p, op, ad, 8'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned wc, cc;
    int n;
    logic seen;
    c_req = 0; c_op = 0; c_addr = 0; c_wdata = 0; c_wbit = 0;
    a_req = 0; a_op = 0; a_addr = 0; a_wdata = 0; a_wbit = 0;
    rst = 1'b1;
    #1;
    chk("rst_c_ack", c_ack, 0);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_cs", ram_CS, 1);
    chk("rst_rw", ram_RW, 1);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    do_txn(0, 3'd1, 8'h30, 8'h55, 1'b0, 1'b1);
    chk("mem30", mem[8'h30], 8'h55);
    do_txn(0, 3'd0, 8'h30, 8'h00, 1'b0, 1'b1);

    do_txn(0, 3'd1, 8'h22, 8'h87, 1'b0, 1'b1);
    do_txn(0, 3'd3, 8'h13, 8'h00, 1'b0, 1'b1);
    chk("setb_byte", mem[8'h22], 8'h8F);
    do_txn(0, 3'd4, 8'h17, 8'h00, 1'b0, 1'b1);
    chk("clrb_byte", mem[8'h22], 8'h0F);
    do_txn(0, 3'd5, 8'h10, 8'h00, 1'b0, 1'b1);
    chk("cplb_byte", mem[8'h22], 8'h0E);

    do_txn(1, 3'd1, 8'h2F, 8'h00, 1'b0, 1'b1);
    do_txn(1, 3'd6, 8'h7F, 8'h00, 1'b1, 1'b1);
    chk("movb_byte", mem[8'h2F], 8'h80);
    do_txn(1, 3'd2, 8'h7F, 8'h00, 1'b0, 1'b1);

    cc = cs_cnt;
    do_txn(0, 3'd3, 8'h85, 8'h00, 1'b0, 1'b1);
    do_txn(0, 3'd7, 8'h22, 8'h00, 1'b0, 1'b1);
    chk("err_no_ram", cs_cnt, cc);

    last_ack = -1;
    chk_alt = 1'b1;
    fork
      for (int k = 0; k < 4; k++) do_txn(0, 3'd0, 8'(8'h20 + k), 8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) do_txn(1, 3'd0, 8'(8'h2C + k), 8'h00, 1'b0, 1'b0);
    join
    chk_alt = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    c_op = 3'd5; c_addr = 8'h10; c_wdata = 8'h00; c_wbit = 1'b0; c_req = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(posedge clk); #1;
      n++;
      seen = ~ram_CS;
    end
    chk("rmw_rd_seen", seen, 1);
    @(posedge clk); #1;
    wc = wr_cnt;
    rst = 1'b1;
    #1;
    chk("arst_c_ack", c_ack, 0);
    chk("arst_c_rdata", c_rdata, 0);
    chk("arst_c_rbit", c_rbit, 0);
    chk("arst_cs", ram_CS, 1);
    chk("arst_rw", ram_RW, 1);
    chk("arst_addr", ram_addr, 0);
    chk("arst_din", ram_din, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("arst_no_wr", wr_cnt, wc);
    chk("arst_mem", mem[8'h22], ref_mem[8'h22]);
    do_txn(0, 3'd5, 8'h10, 8'h00, 1'b0, 1'b1);
    chk("reserve_mem", mem[8'h22], ref_mem[8'h22]);

    fork
      rand_port(0, 30);
      rand_port(1, 30);
    join
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 8'h20; i < 8'h31; i++) chk($sformatf("mem%0h", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
